// File: rtl/ber_pkg.sv
// Shared types and default sizing for the bit-error-rate meter.
package ber_pkg;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam int DEF_SEQ_LEN    = 511;
  localparam int DEF_REG_LEN    = 32;
  localparam int DEF_RESYNC_WIN = 64;
  localparam int DEF_RESYNC_THR = 16;

endpackage

// File: rtl/ber_delay_line.sv
// Reference-bit delay line: tap k presents sx delayed by k+1 enabled samples.
module ber_delay_line
  import ber_pkg::*;
#(
  parameter int  SEQ_LEN   = DEF_SEQ_LEN,
  localparam int SHIFT_LEN = $clog2(SEQ_LEN)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 sx,
  input  logic [SHIFT_LEN-1:0] sel,
  output logic                 tap
);

  logic [SEQ_LEN-1:0] line;

  always_ff @(posedge clk) begin
    if (!rst) begin
      line <= '0;
    end else if (enable) begin
      line <= {line[SEQ_LEN-2:0], sx};
    end
  end

  assign tap = line[sel];

endmodule

// File: rtl/ber_meter.sv
// BER meter: exhaustive delay search over the reference PRBS, then error
// counting at the chosen delay with automatic re-search on loss of lock.
module ber_meter
  import ber_pkg::*;
#(
  parameter int  SEQ_LEN    = DEF_SEQ_LEN,
  parameter int  REG_LEN    = DEF_REG_LEN,
  parameter int  RESYNC_WIN = DEF_RESYNC_WIN,
  parameter int  RESYNC_THR = DEF_RESYNC_THR,
  localparam int SHIFT_LEN  = $clog2(SEQ_LEN)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 clear,
  input  logic                 sx,
  input  logic                 dx,
  output logic                 locked,
  output logic [SHIFT_LEN-1:0] best_shift,
  output logic [REG_LEN-1:0]   bit_count,
  output logic [REG_LEN-1:0]   error_count,
  output logic                 error_flag
);

  localparam int SUM_W = $clog2(SEQ_LEN + 1);
  localparam int WIN_W = $clog2(RESYNC_WIN + 1);
  localparam logic [SHIFT_LEN-1:0] LAST_IDX = SHIFT_LEN'(SEQ_LEN - 1);
  localparam logic [WIN_W-1:0]     WIN_LAST = WIN_W'(RESYNC_WIN - 1);
  localparam logic [WIN_W-1:0]     THR      = WIN_W'(RESYNC_THR);

  state_t                 state;
  logic [SHIFT_LEN-1:0]   shift;
  logic [SHIFT_LEN-1:0]   sample_cnt;
  logic [SHIFT_LEN-1:0]   min_shift;
  logic [SHIFT_LEN-1:0]   tap_sel;
  logic [SHIFT_LEN-1:0]   lock_shift;
  logic [SUM_W-1:0]       win_sum;
  logic [SUM_W-1:0]       min_sum;
  logic [SUM_W-1:0]       sum_nxt;
  logic [WIN_W-1:0]       win_cnt;
  logic [WIN_W-1:0]       win_err;
  logic [WIN_W-1:0]       win_err_nxt;
  logic                   tap;
  logic                   err;
  logic                   resync;

  function automatic logic [REG_LEN-1:0] sat_add(input logic [REG_LEN-1:0] a,
                                                 input logic               b);
    return (&a) ? a : a + REG_LEN'(b);
  endfunction

  ber_delay_line #(
    .SEQ_LEN(SEQ_LEN)
  ) u_delay_line (
    .clk   (clk),
    .rst   (rst),
    .enable(enable),
    .sx    (sx),
    .sel   (tap_sel),
    .tap   (tap)
  );

  // The same tap mux serves the search sweep and the locked comparison.
  assign tap_sel     = (state == LOCKED) ? best_shift : shift;
  assign err         = tap ^ dx;
  assign sum_nxt     = win_sum + SUM_W'(err);
  assign lock_shift  = (sum_nxt < min_sum) ? shift : min_shift;
  assign win_err_nxt = win_err + WIN_W'(err);
  assign resync      = (win_err_nxt >= THR);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= SEARCH;
      shift       <= '0;
      sample_cnt  <= '0;
      win_sum     <= '0;
      min_sum     <= '1;
      min_shift   <= '0;
      win_cnt     <= '0;
      win_err     <= '0;
      locked      <= 1'b0;
      best_shift  <= '0;
      bit_count   <= '0;
      error_count <= '0;
      error_flag  <= 1'b0;
    end else begin
      unique case (state)
        SEARCH: begin
          if (enable) begin
            if (sample_cnt == LAST_IDX) begin
              sample_cnt <= '0;
              win_sum    <= '0;
              if (sum_nxt < min_sum) begin
                min_sum   <= sum_nxt;
                min_shift <= shift;
              end
              if (sum_nxt == '0 || shift == LAST_IDX) begin
                state       <= LOCKED;
                locked      <= 1'b1;
                best_shift  <= lock_shift;
                bit_count   <= '0;
                error_count <= '0;
                error_flag  <= 1'b0;
                win_cnt     <= '0;
                win_err     <= '0;
              end else begin
                shift <= shift + SHIFT_LEN'(1);
              end
            end else begin
              sample_cnt <= sample_cnt + SHIFT_LEN'(1);
              win_sum    <= sum_nxt;
            end
          end
        end
        LOCKED: begin
          // Loss of lock takes priority over a simultaneous clear.
          if (enable && resync) begin
            state       <= SEARCH;
            locked      <= 1'b0;
            best_shift  <= '0;
            bit_count   <= '0;
            error_count <= '0;
            error_flag  <= 1'b0;
            shift       <= '0;
            sample_cnt  <= '0;
            win_sum     <= '0;
            min_sum     <= '1;
            min_shift   <= '0;
            win_cnt     <= '0;
            win_err     <= '0;
          end else begin
            if (enable) begin
              if (win_cnt == WIN_LAST) begin
                win_cnt <= '0;
                win_err <= '0;
              end else begin
                win_cnt <= win_cnt + WIN_W'(1);
                win_err <= win_err_nxt;
              end
            end
            if (clear) begin
              bit_count   <= REG_LEN'(enable);
              error_count <= REG_LEN'(enable & err);
              error_flag  <= enable & err;
            end else if (enable) begin
              bit_count   <= sat_add(bit_count, 1'b1);
              error_count <= sat_add(error_count, err);
              error_flag  <= |sat_add(error_count, err);
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ber_meter.sv
// Directed bench for ber_meter with a sample-history reference model.
module tb_ber_meter;

  localparam int L        = 31;
  localparam int RL       = 10;
  localparam int RW       = 64;
  localparam int RT       = 16;
  localparam int SL       = $clog2(L);
  localparam int CNTMAX   = (1 << RL) - 1;
  localparam int MIN_INIT = (1 << $clog2(L + 1)) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic          clear;
  logic          sx;
  logic          dx;
  logic          locked;
  logic [SL-1:0] best_shift;
  logic [RL-1:0] bit_count;
  logic [RL-1:0] error_count;
  logic          error_flag;

  ber_meter #(
    .SEQ_LEN   (L),
    .REG_LEN   (RL),
    .RESYNC_WIN(RW),
    .RESYNC_THR(RT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .clear      (clear),
    .sx         (sx),
    .dx         (dx),
    .locked     (locked),
    .best_shift (best_shift),
    .bit_count  (bit_count),
    .error_count(error_count),
    .error_flag (error_flag)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  // Reference model: full history of enabled samples since reset.
  bit sxh[$];
  bit dxh[$];
  bit m_locked;
  int m_best, m_min, m_min_shift, search_start, cnt_start, win_start;
  int exp_locked, exp_best, exp_bits, exp_errs, exp_flag;

  logic [4:0]  prbs;
  logic [63:0] txd;

  function automatic void cmp(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic bit tap_at(int n, int k);
    if (n - k - 1 >= 0) return sxh[n-k-1];
    return 1'b0;
  endfunction

  function automatic int mism(int first, int last, int k);
    int s = 0;
    for (int i = first; i <= last; i++) s += int'(tap_at(i, k) ^ dxh[i]);
    return s;
  endfunction

  function automatic void model_outputs();
    int nb, ne;
    exp_locked = int'(m_locked);
    if (m_locked) begin
      nb = sxh.size() - cnt_start;
      ne = mism(cnt_start, sxh.size() - 1, m_best);
      exp_best = m_best;
      exp_bits = (nb > CNTMAX) ? CNTMAX : nb;
      exp_errs = (ne > CNTMAX) ? CNTMAX : ne;
      exp_flag = int'(exp_errs != 0);
    end else begin
      exp_best = 0;
      exp_bits = 0;
      exp_errs = 0;
      exp_flag = 0;
    end
  endfunction

  function automatic void model_reset();
    sxh.delete();
    dxh.delete();
    m_locked     = 1'b0;
    m_best       = 0;
    m_min        = MIN_INIT;
    m_min_shift  = 0;
    search_start = 0;
    cnt_start    = 0;
    win_start    = 0;
    model_outputs();
  endfunction

  function automatic void model_step(bit en, bit clr, bit s, bit d);
    int n, j, sh, sum, we;
    if (!en) begin
      if (m_locked && clr) cnt_start = sxh.size();
    end else begin
      n = sxh.size();
      sxh.push_back(s);
      dxh.push_back(d);
      if (!m_locked) begin
        j  = n - search_start;
        sh = j / L;
        if (j % L == L - 1) begin
          sum = mism(n - L + 1, n, sh);
          if (sum < m_min) begin
            m_min       = sum;
            m_min_shift = sh;
          end
          if (sum == 0 || sh == L - 1) begin
            m_locked  = 1'b1;
            m_best    = m_min_shift;
            cnt_start = n + 1;
            win_start = n + 1;
          end
        end
      end else begin
        if (clr) cnt_start = n;
        we = mism(win_start, n, m_best);
        if (we >= RT) begin
          m_locked     = 1'b0;
          search_start = n + 1;
          m_min        = MIN_INIT;
          m_min_shift  = 0;
        end else if (n - win_start + 1 == RW) begin
          win_start = n + 1;
        end
      end
    end
    model_outputs();
  endfunction

  always @(negedge clk) begin
    if (chk_on) begin
      cmp("locked", int'(locked), exp_locked);
      cmp("best_shift", int'(best_shift), exp_best);
      cmp("bit_count", int'(bit_count), exp_bits);
      cmp("error_count", int'(error_count), exp_errs);
      cmp("error_flag", int'(error_flag), exp_flag);
    end
  end

  task automatic step(input bit r, input bit en, input bit clr, input bit s, input bit d);
    rst    = r;
    enable = en;
    clear  = clr;
    sx     = s;
    dx     = d;
    if (!r) model_reset();
    else model_step(en, clr, s, d);
    @(negedge clk);
    #1;
  endtask

  task automatic sample(input bit en, input bit clr, input int dly, input bit inv);
    bit s, d;
    s = 1'b0;
    d = 1'b0;
    if (en) begin
      s    = prbs[4];
      d    = txd[dly-1] ^ inv;
      prbs = {prbs[3:0], prbs[4] ^ prbs[2]};
    end
    step(1'b1, en, clr, s, d);
    if (en) txd = {txd[62:0], s};
  endtask

  task automatic restart();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    prbs = 5'b00001;
    txd  = '0;
  endtask

  initial begin
    rst    = 1'b0;
    enable = 1'b0;
    clear  = 1'b0;
    sx     = 1'b0;
    dx     = 1'b0;
    prbs   = 5'b00001;
    txd    = '0;
    model_reset();
    @(negedge clk);
    #1;
    chk_on = 1'b1;
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cmp("rst_locked", int'(locked), 0);
    cmp("rst_bits", int'(bit_count), 0);
    cmp("rst_flag", int'(error_flag), 0);

    // Delay 5: lock on the 155th sample at shift 4.
    for (int i = 1; i <= 5 * L; i++) begin
      sample(1'b1, 1'b0, 5, 1'b0);
      if (i == 5 * L - 1) cmp("s033_prelock", int'(locked), 0);
    end
    cmp("s033_lock", int'(locked), 1);
    cmp("s033_shift", int'(best_shift), 4);
    cmp("s033_model_shift", m_best, 4);
    cmp("s033_errs", int'(error_count), 0);

    // Every 100th received bit inverted.
    for (int i = 1; i <= 1000; i++) sample(1'b1, 1'b0, 5, (i % 100) == 0);
    cmp("s034_bits", int'(bit_count), 1000);
    cmp("s034_errs", int'(error_count), 10);
    cmp("s034_flag", int'(error_flag), 1);

    sample(1'b0, 1'b1, 5, 1'b0);
    cmp("clear_bits", int'(bit_count), 0);
    cmp("clear_errs", int'(error_count), 0);
    cmp("clear_flag", int'(error_flag), 0);
    sample(1'b1, 1'b1, 5, 1'b1);
    cmp("clear_en_bits", int'(bit_count), 1);
    cmp("clear_en_errs", int'(error_count), 1);

    for (int i = 1; i <= 1111; i++) sample(1'b1, 1'b0, 5, 1'b0);
    cmp("sat_bits", int'(bit_count), CNTMAX);
    cmp("sat_errs", int'(error_count), 1);

    // All-wrong bits: 16th error forces re-search; clear on that sample loses.
    for (int i = 1; i <= 16; i++) begin
      sample(1'b1, i == 16, 5, 1'b1);
      if (i == 15) cmp("s035_still_locked", int'(locked), 1);
    end
    cmp("s035_unlock", int'(locked), 0);
    cmp("s035_bits", int'(bit_count), 0);
    cmp("s035_errs", int'(error_count), 0);

    // Enable toggling with clears during search.
    for (int i = 1; i <= 5 * L; i++) begin
      sample(1'b1, (i % 7) == 3, 5, 1'b0);
      if (i == 5 * L - 1) cmp("s037_prelock", int'(locked), 0);
      if (i == 5 * L) cmp("s037_lock", int'(locked), 1);
      sample(1'b0, 1'b1, 5, 1'b0);
    end
    cmp("s037_shift", int'(best_shift), 4);

    repeat (5) sample(1'b1, 1'b0, 5, 1'b0);
    restart();
    cmp("s038_locked", int'(locked), 0);
    cmp("s038_shift", int'(best_shift), 0);
    cmp("s038_bits", int'(bit_count), 0);
    for (int i = 1; i <= 5 * L; i++) begin
      sample(1'b1, 1'b0, 5, 1'b0);
      if (i == 5 * L - 1) cmp("s038_prelock", int'(locked), 0);
    end
    cmp("s038_lock", int'(locked), 1);
    cmp("s038_shift_after", int'(best_shift), 4);

    // Delay 9 with every 20th bit flipped: no clean window, full sweep.
    restart();
    for (int i = 0; i < L * L; i++) begin
      sample(1'b1, 1'b0, 9, (i % 20) == 19);
      if (i == L * L - 2) cmp("s036_prelock", int'(locked), 0);
    end
    cmp("s036_lock", int'(locked), 1);
    cmp("s036_shift", int'(best_shift), 8);
    cmp("s036_model_shift", m_best, 8);
    for (int i = L * L; i < L * L + 40; i++) sample(1'b1, 1'b0, 9, (i % 20) == 19);
    cmp("s036_errs", int'(error_count), 2);
    cmp("s036_flag", int'(error_flag), 1);

    chk_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ber_meter.md
BER_METER -- requirements
Module: ber_meter

Interface
REQ-001 Parameter SEQ_LEN, default 511: PRBS period and maximum searched delay; search window length in samples.
REQ-002 Parameter REG_LEN, default 32: width of bit and error counters.
REQ-003 Parameter RESYNC_WIN, default 64: loss-of-lock observation window, in enabled samples.
REQ-004 Parameter RESYNC_THR, default 16: errors per RESYNC_WIN that force re-search; legal range 1..RESYNC_WIN.
REQ-005 Derived constant SHIFT_LEN = clog2(SEQ_LEN).
REQ-006 clk  in  1  single clock; all logic on its rising edge.
REQ-007 rst  in  1  reset; synchronous, active-low.
REQ-008 enable  in  1  sample strobe; nothing advances when low.
REQ-009 clear  in  1  clears bit_count and error_count while locked.
REQ-010 sx  in  1  transmitted reference bit.
REQ-011 dx  in  1  received/detected bit.
REQ-012 locked  out  1  alignment found; counts are valid.
REQ-013 best_shift  out  SHIFT_LEN  selected delay tap.
REQ-014 bit_count  out  REG_LEN  compared bits since lock or last clear.
REQ-015 error_count  out  REG_LEN  mismatches since lock or last clear.
REQ-016 error_flag  out  1  high when locked and error_count is non-zero.

Function
REQ-017 On every enabled cycle, a SEQ_LEN-deep delay line shifts in sx; tap k yields sx delayed by k+1 enabled samples.
REQ-018 FSM has two states: SEARCH and LOCKED; the FSM is in SEARCH after reset.
REQ-019 SEARCH: for shift = 0..SEQ_LEN-1, accumulate (tap[shift] XOR dx) over exactly SEQ_LEN enabled samples per shift.
REQ-020 On the SEQ_LEN-th sample of a shift, evaluate the window sum including that sample; if it is strictly less than the running minimum, store the sum and shift (ties keep the earlier shift).
REQ-021 A window sum of 0 locks immediately at that shift; otherwise, after shift SEQ_LEN-1 is evaluated, lock to the stored minimum shift.
REQ-022 Entering LOCKED: locked=1 on the next cycle; best_shift, bit_count and error_count are 0 on entry, and best_shift then holds the chosen shift.
REQ-023 LOCKED: each enabled sample increments bit_count and adds (tap[best_shift] XOR dx) to error_count; both counters saturate at all-ones with no wrap.
REQ-024 clear in LOCKED zeroes both counters; clear coincident with an enabled sample leaves bit_count=1 and error_count equal to that sample's error; clear in SEARCH is ignored.
REQ-025 LOCKED: a window counter runs over RESYNC_WIN enabled samples; if window errors reach RESYNC_THR, return to SEARCH next cycle: locked=0, shift restarts at 0, minimum resets to all-ones, counters zero; otherwise the window restarts.
REQ-026 Resync and clear in the same cycle: resync wins.
REQ-027 Delay-line contents persist across SEARCH and LOCKED transitions and are cleared only by reset.

Reset
REQ-028 rst=0 at a clock edge forces state SEARCH, shift=0, minimum=all-ones, delay line=0, and all window counters=0.
REQ-029 rst=0 at a clock edge forces locked=0, best_shift=0, bit_count=0, error_count=0, error_flag=0.
REQ-030 Reset mid-search or mid-lock discards all progress; operation restarts from shift 0 at the first enabled cycle after rst=1.

Structure
REQ-031 Shared package ber_pkg holds the state enum (SEARCH, LOCKED) and the default values of SEQ_LEN, REG_LEN, RESYNC_WIN and RESYNC_THR.
REQ-032 Sub-module ber_delay_line implements the parametrised sx shift register and variable tap mux; the FSM and counters remain in ber_meter.

Verification
REQ-033 Scenario: PRBS9 sx, dx = sx delayed 5 samples, enable=1 -> locked rises one cycle after the 2555th sample, best_shift=4, error_count stays 0.
REQ-034 Scenario: lock as in REQ-033, then invert every 100th dx -> after 1000 samples, bit_count=1000, error_count=10, error_flag=1.
REQ-035 Scenario: locked, then dx random -> within 64 samples, 16 errors reached, locked=0, counts=0, and the search restarts at shift 0.
REQ-036 Scenario: dx never matches with zero errors (every 50th bit flipped) -> full 511-shift search, locked after 511*511 samples, best_shift = true delay-1.
REQ-037 Scenario: enable toggling 1/0 -> the same results as REQ-033 in enabled-sample terms; clear during SEARCH -> no effect.
REQ-038 Scenario: rst=0 for 1 cycle while locked -> next cycle all outputs 0 and re-lock timing identical to REQ-033.
